// File: rtl/gcd_apb_pkg.sv
// Shared definitions for the GCD wrapper's APB path.
//   - APB address and data widths
//   - bridge state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   - word_align: clears the byte-lane bits of an APB address
package gcd_apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
  localparam logic [1:0] ST_RESP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETUP  = ST_SETUP_ENC,
    ST_ACCESS = ST_ACCESS_ENC,
    ST_RESP   = ST_RESP_ENC
  } apb_state_e;

  // The APB slave only decodes whole words, so the two byte-lane bits are zeroed.
  function automatic logic [APB_ADDR_W-1:0] word_align(input logic [APB_ADDR_W-1:0] addr);
    return addr & ~APB_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 initiator. Takes one request at a time from a valid/ready request
// channel, runs it as an APB SETUP + ACCESS transfer and returns read data
// and status on a valid/ready response channel. A hung slave is cut off
// after TIMEOUT ACCESS cycles (TIMEOUT = 0 waits forever).
//
// Ports
//   CLK, RESETn                        clock, async active-low reset
//   REQ_VALID/REQ_READY                request handshake (ready only in IDLE)
//   REQ_WRITE, REQ_ADDR, REQ_WDATA     request payload
//   RSP_VALID/RSP_READY                response handshake
//   RSP_RDATA, RSP_ERR, RSP_TIMEOUT    response payload
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA                             APB initiator outputs
//   PREADY, PSLVERR, PRDATA            APB slave returns
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | REQ_READY=1, waiting for a request
// SETUP  | APB setup phase, PSEL=1 PENABLE=0, one cycle
// ACCESS | APB access phase, waiting for PREADY or the timeout
// RESP   | RSP_VALID=1, response held until RSP_READY
module apb_master_bridge
  import gcd_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [APB_ADDR_W-1:0] REQ_ADDR,
  input  logic [APB_DATA_W-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [APB_DATA_W-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [APB_DATA_W-1:0] PRDATA
);

  // Down-counter loaded in SETUP; the abort fires when it has reached zero
  // on a not-ready ACCESS cycle, i.e. on the TIMEOUT-th ACCESS cycle.
  localparam logic [CNT_W-1:0] TC_LOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam bit               TMO_EN  = (TIMEOUT != 0);

  apb_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= ST_IDLE;
      REQ_READY   <= 1'b1;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            PWRITE    <= REQ_WRITE;
            PADDR     <= word_align(REQ_ADDR);
            PWDATA    <= REQ_WDATA;
            REQ_READY <= 1'b0;
            PSEL      <= 1'b1;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          tmo_cnt <= TC_LOAD;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // PREADY is checked first so a completion on the last allowed
          // cycle is reported as a normal transfer, not a timeout.
          if (PREADY) begin
            RSP_RDATA   <= PWRITE ? '0 : PRDATA;
            RSP_ERR     <= PSLVERR;
            RSP_TIMEOUT <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            RSP_VALID   <= 1'b1;
            state       <= ST_RESP;
          end else if (TMO_EN && (tmo_cnt == '0)) begin
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b1;
            RSP_TIMEOUT <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            RSP_VALID   <= 1'b1;
            state       <= ST_RESP;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          RSP_VALID <= 1'b0;
          REQ_READY <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus random
// transfers against a word-array reference memory and a latency model.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam int BUDGET  = 60;

  logic        CLK;
  logic        RESETn;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  apb_master_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full transfer. waits = not-ready ACCESS cycles before PREADY
  // (>= TIMEOUT means the slave never answers in time).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic err, input int stall);
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        tmo;
    int          idx, exp_lat, exp_acc;
    int          off, acc_k, setup_cnt, first_sel, bad_addr, bad_ctl, bad_hold;

    exp_addr  = {addr[31:2], 2'b00};
    idx       = int'(addr[7:2]);
    tmo       = (waits >= TIMEOUT);
    exp_lat   = tmo ? TIMEOUT + 2 : waits + 3;
    exp_acc   = tmo ? TIMEOUT : waits + 1;
    exp_rdata = (wr || tmo) ? 32'h0 : ref_mem[idx];
    exp_err   = tmo ? 1'b1 : err;

    chk("req_ready_idle", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1;
    REQ_WRITE = wr;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    step();
    // Scramble the request bus so anything not latched at accept shows up.
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'($urandom);
    REQ_ADDR  = $urandom;
    REQ_WDATA = $urandom;

    off = 1; acc_k = 0; setup_cnt = 0; first_sel = -1; bad_addr = 0; bad_ctl = 0;
    while (!RSP_VALID && off < BUDGET) begin
      if (PSEL && !PENABLE) begin
        setup_cnt++;
        if (first_sel < 0) first_sel = off;
      end
      if (PENABLE && !PSEL) bad_ctl++;
      if (PSEL) begin
        if (PADDR !== exp_addr) bad_addr++;
        if (PWRITE !== wr) bad_ctl++;
        if (wr && (PWDATA !== wdata)) bad_ctl++;
      end
      if (PSEL && PENABLE) begin
        acc_k++;
        if (acc_k > waits) begin
          PREADY  = 1'b1;
          PSLVERR = err;
          PRDATA  = slv_mem[PADDR[7:2]];
          if (PWRITE && !err) slv_mem[PADDR[7:2]] = PWDATA;
        end else begin
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom);
          PRDATA  = $urandom;
        end
      end else begin
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
      step();
      off++;
    end
    PREADY = 1'b0;

    chk("rsp_latency", 32'(off), 32'(exp_lat));
    chk("setup_cycles", 32'(setup_cnt), 32'd1);
    chk("setup_offset", 32'(first_sel), 32'd1);
    chk("access_cycles", 32'(acc_k), 32'(exp_acc));
    chk("paddr_stable", 32'(bad_addr), 32'd0);
    chk("ctl_stable", 32'(bad_ctl), 32'd0);
    chk("rsp_rdata", RSP_RDATA, exp_rdata);
    chk("rsp_err", 32'(RSP_ERR), 32'(exp_err));
    chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(tmo));
    chk("psel_in_resp", 32'({PSEL, PENABLE}), 32'd0);
    chk("req_ready_resp", 32'(REQ_READY), 32'd0);

    if (wr && !tmo && !err) ref_mem[idx] = wdata;

    bad_hold = 0;
    for (int i = 0; i < stall; i++) begin
      REQ_VALID = 1'b1;
      REQ_ADDR  = $urandom;
      RSP_READY = 1'b0;
      step();
      if (!RSP_VALID || (RSP_RDATA !== exp_rdata) || (RSP_ERR !== exp_err) ||
          (RSP_TIMEOUT !== tmo) || REQ_READY || PSEL || PENABLE)
        bad_hold++;
    end
    chk("rsp_hold", 32'(bad_hold), 32'd0);

    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    step();
    RSP_READY = 1'b0;
    chk("rsp_done", 32'(RSP_VALID), 32'd0);
    chk("idle_ready", 32'(REQ_READY), 32'd1);
    chk("idle_no_psel", 32'(PSEL), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wsel;
    int waits;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      slv_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    ref_mem[0] = 32'h5A5A_5A5A;
    slv_mem[0] = 32'h5A5A_5A5A;

    RESETn = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    RSP_READY = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    chk("rst_psel_penable", 32'({PSEL, PENABLE}), 32'd0);
    chk("rst_rsp_flags", 32'({RSP_VALID, RSP_ERR, RSP_TIMEOUT}), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    step();

    // Directed cases
    xfer(1'b0, 32'h0, 32'h0, 0, 1'b0, 0);
    xfer(1'b1, 32'h4, 32'h1, 0, 1'b0, 0);
    xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 0);
    xfer(1'b0, 32'h8, 32'h0, 3, 1'b1, 0);
    xfer(1'b0, 32'hC, 32'h0, 1000, 1'b0, 0);
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 1000, 1'b0, 0);
    xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 10);
    xfer(1'b0, 32'h14, 32'h0, TIMEOUT - 1, 1'b0, 0);
    xfer(1'b0, 32'h14, 32'h0, TIMEOUT, 1'b0, 0);
    xfer(1'b1, 32'h23, 32'h1234_5678, 2, 1'b0, 1);
    xfer(1'b0, 32'h21, 32'h0, 0, 1'b0, 0);

    // Random transfers
    for (int t = 0; t < 40; t++) begin
      wsel = int'($urandom_range(0, 7));
      case (wsel)
        0, 1, 2: waits = 0;
        3, 4:    waits = int'($urandom_range(1, 4));
        5:       waits = TIMEOUT - 1;
        6:       waits = TIMEOUT;
        default: waits = TIMEOUT + int'($urandom_range(1, 8));
      endcase
      xfer(1'($urandom), 32'($urandom_range(0, 255)), $urandom, waits,
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of an ACCESS phase
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h8; PREADY = 1'b0;
    step();
    REQ_VALID = 1'b0;
    step();
    chk("pre_rst_access", 32'({PSEL, PENABLE}), 32'd3);
    #2;
    RESETn = 1'b0;
    #1;
    chk("async_rst_psel", 32'({PSEL, PENABLE}), 32'd0);
    chk("async_rst_rsp", 32'(RSP_VALID), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    step();
    step();
    chk("post_rst_ready", 32'(REQ_READY), 32'd1);
    chk("post_rst_no_rsp", 32'({RSP_VALID, PSEL}), 32'd0);
    xfer(1'b0, 32'h0, 32'h0, 1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
